// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the MEMU port arbiter: FSM states and requester IDs.
package mem_port_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_WAIT  = 2'd2;
   localparam logic [1:0] ARB_RESP  = 2'd3;

   localparam logic ARB_ID_IF = 1'b0;
   localparam logic ARB_ID_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: combinational grant, registered last-grant pointer.
module rr_arbiter2
   import mem_port_arbiter_pkg::*;
(
   input  logic       Global_clk,
   input  logic       Global_rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       upd_id,
   output logic [1:0] gnt
);

   logic last_id;

   // NOTE: reset is synchronous, so it lives inside the clocked block; state uses <= only.
   always_ff @(posedge Global_clk) begin
      if (!Global_rst_n) begin
         last_id <= ARB_ID_LS;   // IF wins the first tie
      end else if (update) begin
         last_id <= upd_id;
      end
   end

   // NOTE: gnt gets a default before any branch so no latch is inferred.
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = (last_id == ARB_ID_LS) ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single MEMU port between IF (read-only) and LS (read/write).
// Optional WAIT timeout with Err flag is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 16
`endif
) (
   input  logic              Global_clk,
   input  logic              Global_rst_n,
   input  logic              If_req,
   input  logic [ADDR_W-1:0] If_addr,
   output logic              If_done,
   output logic [DATA_W-1:0] If_rdata,
   input  logic              Ls_req,
   input  logic              Ls_we,
   input  logic [ADDR_W-1:0] Ls_addr,
   input  logic [DATA_W-1:0] Ls_wdata,
   output logic              Ls_done,
   output logic [DATA_W-1:0] Ls_rdata,
   output logic              Read_sig,
   output logic              Write_sig,
   output logic              Mem_op_enable,
   output logic [ADDR_W-1:0] MAR,
   output logic [DATA_W-1:0] MDR_out,
   input  logic [DATA_W-1:0] MDR_in,
   input  logic              Mem_op_success,
   output logic              Busy,
`ifdef MEM_ARB_TIMEOUT_EN
   output logic              Err,
`endif
   output logic              Grant_id
);

   logic [1:0]        state;
   logic [1:0]        gnt;
   logic              done_q;
   logic [DATA_W-1:0] rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wait_cnt;
`endif

   rr_arbiter2 u_rr (
      .Global_clk   (Global_clk),
      .Global_rst_n (Global_rst_n),
      .req          ({Ls_req, If_req}),
      .update       (state == ARB_RESP),
      .upd_id       (Grant_id),
      .gnt          (gnt)
   );

   always_ff @(posedge Global_clk) begin
      if (!Global_rst_n) begin
         state         <= ARB_IDLE;
         MAR           <= '0;
         MDR_out       <= '0;
         Read_sig      <= 1'b0;
         Write_sig     <= 1'b0;
         Mem_op_enable <= 1'b0;
         Grant_id      <= ARB_ID_IF;
         done_q        <= 1'b0;
         rdata_q       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         Err           <= 1'b0;
         wait_cnt      <= '0;
`endif
      end else begin
         Mem_op_enable <= 1'b0;
         done_q        <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (gnt != 2'b00) begin
                  if (gnt[ARB_ID_LS]) begin
                     MAR       <= Ls_addr;
                     MDR_out   <= Ls_wdata;
                     Write_sig <= Ls_we;
                     Read_sig  <= !Ls_we;
                     Grant_id  <= ARB_ID_LS;
                  end else begin
                     MAR       <= If_addr;
                     Write_sig <= 1'b0;
                     Read_sig  <= 1'b1;
                     Grant_id  <= ARB_ID_IF;
                  end
                  Mem_op_enable <= 1'b1;
                  state         <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               state <= ARB_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ARB_WAIT: begin
               if (Mem_op_success) begin
                  rdata_q <= MDR_in;
                  done_q  <= 1'b1;
                  state   <= ARB_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  // Forced completion: empty data, flagged as an error.
                  rdata_q <= '0;
                  done_q  <= 1'b1;
                  Err     <= 1'b1;
                  state   <= ARB_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
`endif
               end
            end
            ARB_RESP: begin
               Read_sig  <= 1'b0;
               Write_sig <= 1'b0;
               state     <= ARB_IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
               Err       <= 1'b0;
`endif
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign Busy     = (state != ARB_IDLE);
   assign If_done  = done_q && (Grant_id == ARB_ID_IF);
   assign Ls_done  = done_q && (Grant_id == ARB_ID_LS);
   assign If_rdata = If_done ? rdata_q : '0;
   assign Ls_rdata = Ls_done ? rdata_q : '0;

endmodule
